// File: rtl/pipeline_adder_arbiter_pkg.sv
// Shared sizing helpers, result-entry layout and round-robin pointer arithmetic
// for the pipelined-adder arbiter.
package pipeline_adder_arbiter_pkg;

  function automatic int calc_idw(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int rsp_width(input int idw, input int dwidth);
    return idw + 1 + dwidth;
  endfunction

  // Next round-robin start position: one past the winner, wrapping at num_req.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
    return ((idx + 32'd1) >= num_req) ? 32'd0 : (idx + 32'd1);
  endfunction

  // Result entry layout at the default configuration (NUM_REQ=4, DWIDTH=8).
  typedef struct packed {
    logic [1:0] id;
    logic       carry;
    logic [7:0] sum;
  } rsp_entry_t;

endpackage

// File: rtl/pipeline_adder_arbiter_sync_fifo.sv
// Synchronous FIFO with registered storage; first pushed word is visible one
// cycle after the push. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_adder_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined adder among NUM_REQ requesters;
// results return tagged with the requester index, in issue order, via a credit-guarded FIFO.
module pipeline_adder_arbiter
  import pipeline_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DWIDTH     = 8,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DWIDTH-1:0]     req_in1,
  input  logic [NUM_REQ*DWIDTH-1:0]     req_in2,
  output logic [DWIDTH-1:0]             add_in1,
  output logic [DWIDTH-1:0]             add_in2,
  output logic                          add_ivalid,
  input  logic [DWIDTH-1:0]             add_sum,
  input  logic                          add_carry,
  input  logic                          add_ovalid,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [calc_idw(NUM_REQ)-1:0]  rsp_id,
  output logic [DWIDTH-1:0]             rsp_sum,
  output logic                          rsp_carry,
  output logic                          err_align
);
  localparam int IDW = calc_idw(NUM_REQ);
  localparam int RW  = rsp_width(IDW, DWIDTH);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

  logic [IDW-1:0]             r_ptr;
  logic [CW-1:0]              r_inflight;
  logic [LATENCY:0]           r_tag_v;
  logic [LATENCY:0][IDW-1:0]  r_tag_id;
  logic [IDW-1:0]             w_gnt_idx;
  logic [IDW-1:0]             w_cand;
  logic                       w_any;
  logic                       w_found;
  logic                       w_credit_ok;
  logic [CW-1:0]              w_outstanding;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [FCW-1:0]             w_fifo_count;
  logic [RW-1:0]              w_fifo_wdata;
  logic [RW-1:0]              w_fifo_rdata;

  // Same-cycle pops are deliberately not credited, keeping the check off the consumer path.
  assign w_outstanding = r_inflight + CW'(w_fifo_count);
  assign w_credit_ok   = !rst && !w_full && (w_outstanding < CW'(FIFO_DEPTH));

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = r_ptr;
    w_cand    = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand    = IDW'((int'(r_ptr) + k) % NUM_REQ);
      w_gnt_idx = (!w_any && req_valid[w_cand]) ? w_cand : w_gnt_idx;
      w_any     = w_any | req_valid[w_cand];
    end
  end

  assign w_found   = w_any & w_credit_ok;
  assign req_ready = w_found ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  // Issue stage towards the adder plus round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_in1    <= '0;
      add_in2    <= '0;
      add_ivalid <= 1'b0;
      r_ptr      <= '0;
    end else if (w_found) begin
      add_in1    <= req_in1[w_gnt_idx*DWIDTH +: DWIDTH];
      add_in2    <= req_in2[w_gnt_idx*DWIDTH +: DWIDTH];
      add_ivalid <= 1'b1;
      r_ptr      <= IDW'(rr_next(32'(w_gnt_idx), 32'(NUM_REQ)));
    end else begin
      add_ivalid <= 1'b0;
    end
  end

  // Tag shift register: entry LATENCY lines up with the adder's ovalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[LATENCY-1:0], w_found};
      r_tag_id[0] <= w_gnt_idx;
      for (int k = 1; k <= LATENCY; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // In-flight count: one per valid tag still inside the adder pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_found, r_tag_v[LATENCY]})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Sticky alignment error; an untagged ovalid is flagged and never pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_align <= 1'b0;
    end else if (add_ovalid != r_tag_v[LATENCY]) begin
      err_align <= 1'b1;
    end else begin
      err_align <= err_align;
    end
  end

  assign w_push       = add_ovalid & r_tag_v[LATENCY];
  assign w_pop        = rsp_valid & rsp_ready;
  assign w_fifo_wdata = {r_tag_id[LATENCY], add_carry, add_sum};

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_fifo_wdata),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign rsp_valid = ~w_empty;
  assign rsp_id    = w_fifo_rdata[RW-1 -: IDW];
  assign rsp_carry = w_fifo_rdata[DWIDTH];
  assign rsp_sum   = w_fifo_rdata[DWIDTH-1:0];

endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// Directed bench for pipeline_adder_arbiter with a 2-stage adder model in the loop.
module tb_pipeline_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DWIDTH  = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DWIDTH-1:0] req_in1;
  logic [NUM_REQ*DWIDTH-1:0] req_in2;
  logic [DWIDTH-1:0]         add_in1;
  logic [DWIDTH-1:0]         add_in2;
  logic                      add_ivalid;
  logic [DWIDTH-1:0]         add_sum;
  logic                      add_carry;
  logic                      add_ovalid;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [1:0]                rsp_id;
  logic [DWIDTH-1:0]         rsp_sum;
  logic                      rsp_carry;
  logic                      err_align;
  logic                      force_ov;

  logic [1:0] m_v;
  logic [8:0] m_d0;
  logic [8:0] m_d1;

  int n_assert = 0;
  int n_fail   = 0;
  int issue_cnt = 0;
  int bad_ready = 0;
  int budget;
  logic [1:0] gq [$];
  logic [1:0] rq_id [$];
  logic [7:0] rq_sum [$];
  logic       rq_c [$];

  logic [1:0] exp_id  [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] exp_sum [8] = '{8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};

  always #5 clk = ~clk;

  pipeline_adder_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .add_in1(add_in1), .add_in2(add_in2),
    .add_ivalid(add_ivalid), .add_sum(add_sum), .add_carry(add_carry),
    .add_ovalid(add_ovalid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .err_align(err_align)
  );

  // Two-stage adder model sharing the DUT reset.
  always @(posedge clk) begin
    if (rst) begin
      m_v <= 2'b00;
    end else begin
      m_v  <= {m_v[0], add_ivalid};
      m_d0 <= {1'b0, add_in1} + {1'b0, add_in2};
      m_d1 <= m_d0;
    end
  end
  assign add_ovalid = m_v[1] | force_ov;
  assign add_sum    = m_d1[7:0];
  assign add_carry  = m_d1[8];

  // Record transfers and pops mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          gq.push_back(2'(i));
          issue_cnt++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rq_id.push_back(rsp_id);
        rq_sum.push_back(rsp_sum);
        rq_c.push_back(rsp_carry);
      end
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) bad_ready++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_issues(input int n);
    budget = 0;
    while (issue_cnt < n && budget < 60) begin
      cyc(1);
      budget++;
    end
  endtask

  task automatic wait_rsp(input int n);
    budget = 0;
    while (rq_id.size() < n && budget < 60) begin
      cyc(1);
      budget++;
    end
  endtask

  task automatic clear_q();
    gq.delete(); rq_id.delete(); rq_sum.delete(); rq_c.delete();
    issue_cnt = 0;
  endtask

  task automatic check_rsp8(input string tag);
    chk({tag, " nrsp"}, rq_id.size(), 8);
    for (int k = 0; k < 8 && k < rq_id.size(); k++) begin
      chk({tag, " id"}, rq_id[k], exp_id[k]);
      chk({tag, " sum"}, rq_sum[k], exp_sum[k]);
      chk({tag, " carry"}, rq_c[k], 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; force_ov = 1'b0; rsp_ready = 1'b0;
    req_valid = 4'hF; req_in1 = '0; req_in2 = '0;
    cyc(2);
    chk("rst req_ready", req_ready, 4'h0);
    chk("rst add_ivalid", add_ivalid, 1'b0);
    chk("rst add_in1", add_in1, 8'h00);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst err_align", err_align, 1'b0);
    rst = 1'b0; req_valid = 4'h0; rsp_ready = 1'b1;
    cyc(1);

    // Single request from requester 0, 4-cycle latency.
    clear_q();
    req_in1 = {8'h00, 8'h00, 8'h00, 8'h0F}; req_in2 = {8'h00, 8'h00, 8'h00, 8'h01};
    req_valid = 4'b0001;
    #1 chk("t2 ready", req_ready, 4'b0001);
    cyc(1); req_valid = 4'h0;
    chk("t2 ivalid", add_ivalid, 1'b1);
    chk("t2 add_in1", add_in1, 8'h0F);
    chk("t2 add_in2", add_in2, 8'h01);
    cyc(2); chk("t2 early", rsp_valid, 1'b0);
    cyc(1);
    chk("t2 rsp_valid", rsp_valid, 1'b1);
    chk("t2 rsp_id", rsp_id, 2'd0);
    chk("t2 rsp_sum", rsp_sum, 8'h10);
    chk("t2 rsp_carry", rsp_carry, 1'b0);
    cyc(1); chk("t2 popped", rsp_valid, 1'b0);

    // Carry out from requester 1.
    req_in1 = {8'h00, 8'h00, 8'hFF, 8'h00}; req_in2 = {8'h00, 8'h00, 8'h02, 8'h00};
    req_valid = 4'b0010;
    #1 chk("t4 ready", req_ready, 4'b0010);
    cyc(1); req_valid = 4'h0;
    cyc(3);
    chk("t4 rsp_valid", rsp_valid, 1'b1);
    chk("t4 rsp_id", rsp_id, 2'd1);
    chk("t4 rsp_sum", rsp_sum, 8'h01);
    chk("t4 rsp_carry", rsp_carry, 1'b1);
    cyc(2);

    // All requesters, consumer always ready; pointer now starts at 2.
    clear_q();
    req_in1 = {8'h40, 8'h30, 8'h20, 8'h10}; req_in2 = {8'h04, 8'h03, 8'h02, 8'h01};
    req_valid = 4'hF;
    wait_issues(8);
    req_valid = 4'h0;
    chk("t3 issues", issue_cnt, 8);
    for (int k = 0; k < 8 && k < gq.size(); k++) chk("t3 grant", gq[k], exp_id[k]);
    wait_rsp(8);
    check_rsp8("t3");

    // Back-pressure: only FIFO_DEPTH issues, resume only after pops.
    cyc(2);
    clear_q();
    rsp_ready = 1'b0; req_valid = 4'hF;
    cyc(12);
    chk("t5 stalled issues", issue_cnt, 4);
    chk("t5 stalled ready", req_ready, 4'h0);
    chk("t5 head valid", rsp_valid, 1'b1);
    chk("t5 head id", rsp_id, 2'd2);
    rsp_ready = 1'b1;
    #1 chk("t5 no same-cycle credit", req_ready, 4'h0);
    cyc(1); chk("t5 resume ready", req_ready, 4'b0100);
    wait_issues(8);
    req_valid = 4'h0;
    chk("t5 issues", issue_cnt, 8);
    wait_rsp(8);
    check_rsp8("t5");

    // Spurious adder ovalid with an empty tag pipe.
    cyc(3);
    clear_q();
    chk("t6 err before", err_align, 1'b0);
    force_ov = 1'b1;
    cyc(1); force_ov = 1'b0;
    chk("t6 err set", err_align, 1'b1);
    chk("t6 no push", rsp_valid, 1'b0);
    cyc(3);
    chk("t6 err sticky", err_align, 1'b1);
    chk("t6 no rsp", rq_id.size(), 0);

    // Reset with three issues in flight: everything discarded.
    clear_q();
    req_valid = 4'hF;
    wait_issues(3);
    rst = 1'b1;
    #1 chk("t1 ready in rst", req_ready, 4'h0);
    req_valid = 4'h0;
    cyc(1); rst = 1'b0;
    chk("t1 ivalid", add_ivalid, 1'b0);
    chk("t1 add_in1", add_in1, 8'h00);
    chk("t1 add_in2", add_in2, 8'h00);
    chk("t1 rsp_valid", rsp_valid, 1'b0);
    chk("t1 err_align", err_align, 1'b0);
    cyc(8);
    chk("t1 no rsp", rq_id.size(), 0);
    chk("t1 rsp_valid late", rsp_valid, 1'b0);
    chk("t1 issues", issue_cnt, 3);
    chk("ready onehot", bad_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
